// File: rtl/pwm_halfbridge_nch.sv
// pwm_halfbridge_nch
//   Multi-channel complementary PWM generator for half-bridge power stages.
//   One shared time base drives CH high/low gate pairs. Each pair has its own
//   shadowed duty word and dead-time counter. A control-loop interrupt pulses
//   once every INT_DIV PWM periods.
//
//   Build option: define PWM_CENTER_ALIGNED_EN for a triangular (up/down)
//   time base with the period start at the valley. Without it the time base
//   is an edge-aligned sawtooth.
//
// Ports
//   clk    in        system clock, the only clock of the block
//   rst_n  in        asynchronous active-low reset
//   en     in        run enable; low holds the bridge off and the time base at 0
//   duty   in  CH*DW duty words, channel i at [i*DW +: DW]
//   s      out CH    high-side gate commands (registered)
//   nots   out CH    low-side gate commands (registered)
//   irq    out 1     one-clk period interrupt pulse (registered)
module pwm_halfbridge_nch #(
   parameter int CH      = 1,
   parameter int DW      = 10,
   parameter int PERIOD  = 1000,
   parameter int PRESC   = 4,
   parameter int DT      = 8,
   parameter int INT_DIV = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [CH*DW-1:0]   duty,
   output logic [CH-1:0]      s,
   output logic [CH-1:0]      nots,
   output logic               irq
);

   localparam int PW  = (PRESC > 1)   ? $clog2(PRESC)   : 1;
   localparam int IW  = (INT_DIV > 1) ? $clog2(INT_DIV) : 1;
   localparam int DTW = (DT > 0)      ? $clog2(DT + 1)  : 1;

   localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESC - 1);
   localparam logic [DW-1:0]  CNT_LAST   = DW'(PERIOD - 1);
   localparam logic [IW-1:0]  ICNT_LAST  = IW'(INT_DIV - 1);
   localparam logic [DTW-1:0] DT_SAT     = DTW'(DT);

   logic [PW-1:0] r_presc;
   logic [DW-1:0] r_cnt;
   logic [DW-1:0] w_cnt_next;
   logic [IW-1:0] r_icnt;
   logic [IW-1:0] w_icnt_next;
   logic          r_first;   // set until the first tick after reset / enable
   logic          r_irq;
   logic          w_tick;
   logic          w_pstart;
   logic          w_adv;

   assign w_tick = (r_presc == PRESC_LAST);

   // The first tick after start-up only arms the time base (it is the period
   // start); the output pipeline starts evaluating cnt=0 on the tick after.
   assign w_adv = w_tick && !r_first;

`ifdef PWM_CENTER_ALIGNED_EN
   logic r_up;

   always_comb begin
      w_cnt_next = r_cnt;
      if (r_first) begin
         w_cnt_next = '0;
      end else if (r_up && (r_cnt != CNT_LAST)) begin
         w_cnt_next = r_cnt + DW'(1);
      end else begin
         // Turning at the peak or counting down towards the valley.
         w_cnt_next = r_cnt - DW'(1);
      end
   end
`else
   always_comb begin
      w_cnt_next = r_cnt + DW'(1);
      if (r_first || (r_cnt == CNT_LAST)) begin
         w_cnt_next = '0;
      end
   end
`endif

   // Both time-base shapes only ever reach 0 at a period start.
   assign w_pstart    = w_tick && (w_cnt_next == '0);
   assign w_icnt_next = (r_icnt == ICNT_LAST) ? '0 : r_icnt + IW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_cnt   <= '0;
         r_icnt  <= '0;
         r_first <= 1'b1;
         r_irq   <= 1'b0;
      end else if (!en) begin
         r_presc <= '0;
         r_cnt   <= '0;
         r_icnt  <= '0;
         r_first <= 1'b1;
         r_irq   <= 1'b0;
      end else begin
         r_irq   <= 1'b0;
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) begin
            r_cnt   <= w_cnt_next;
            r_first <= 1'b0;
            if (w_pstart) begin
               r_icnt <= w_icnt_next;
               r_irq  <= (w_icnt_next == '0);
            end
         end
      end
   end

`ifdef PWM_CENTER_ALIGNED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_up <= 1'b1;
      end else if (!en) begin
         r_up <= 1'b1;
      end else if (w_tick) begin
         if (w_pstart) begin
            r_up <= 1'b1;
         end else if (r_up && (r_cnt == CNT_LAST)) begin
            r_up <= 1'b0;
         end
      end
   end
`endif

   assign irq = r_irq;

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         logic [DW-1:0]  r_duty_sh;
         logic [DTW-1:0] r_dtc;
         logic [DTW-1:0] w_dtc_next;
         logic           r_raw_prev;
         logic           r_s;
         logic           r_nots;
         logic           w_raw;
         logic           w_stable;

         assign w_raw = (r_cnt < r_duty_sh);

         // Any demand edge restarts the dead-time count; both gates stay off
         // until the demand has been stable for DT ticks.
         always_comb begin
            w_dtc_next = r_dtc;
            if (w_raw != r_raw_prev) begin
               w_dtc_next = '0;
            end else if (r_dtc != DT_SAT) begin
               w_dtc_next = r_dtc + DTW'(1);
            end
         end

         assign w_stable = (w_dtc_next == DT_SAT);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_duty_sh  <= '0;
               r_dtc      <= '0;
               r_raw_prev <= 1'b0;
               r_s        <= 1'b0;
               r_nots     <= 1'b0;
            end else if (!en) begin
               r_duty_sh  <= duty[gi*DW +: DW];
               r_dtc      <= '0;
               r_raw_prev <= 1'b0;
               r_s        <= 1'b0;
               r_nots     <= 1'b0;
            end else begin
               // Keep tracking duty until the time base is armed, then only
               // at period starts so a mid-period write cannot glitch a pulse.
               if (r_first || w_pstart) begin
                  r_duty_sh <= duty[gi*DW +: DW];
               end
               if (w_adv) begin
                  r_raw_prev <= w_raw;
                  r_dtc      <= w_dtc_next;
                  r_s        <= w_raw && w_stable;
                  r_nots     <= !w_raw && w_stable;
               end
            end
         end

         assign s[gi]    = r_s;
         assign nots[gi] = r_nots;
      end
   endgenerate

endmodule

// File: doc/pwm_halfbridge_nch.md
# pwm_halfbridge_nch

Parametrised multi-channel complementary PWM generator with per-channel dead time, shadowed duty registers and a period interrupt. It replaces the fixed single-channel half-bridge driver in the MG power stages. It derives its own PWM tick from the system clock and drives `CH` high/low switch pairs that share one time base. It also raises the control-loop interrupt at a programmable multiple of the PWM period.

## Interface
- `CH`, 1: number of half-bridge channels.
- `DW`, 10: duty word width per channel.
- `PERIOD`, 1000: PWM period in ticks (edge-aligned). Legal range 2..2^DW.
- `PRESC`, 4: clk cycles per PWM tick. PRESC ≥ 1; PRESC=1 means every clk is a tick.
- `DT`, 8: dead time in ticks. DT=0 disables dead time.
- `INT_DIV`, 1: PWM periods per interrupt pulse. INT_DIV ≥ 1.

Ports:
- `clk`  in  1  system clock (100 MHz); the block's only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  run enable. When low, the bridge is held off and the time base is held at zero.
- `duty`  in  CH*DW  duty words; channel i is at bits [i*DW +: DW].
- `s`  out  CH  high-side gate commands, registered.
- `nots`  out  CH  low-side gate commands, registered.
- `irq`  out  1  one-clk interrupt pulse, registered.

## Operation
- **Prescaler**
  - Counts 0..PRESC-1.
  - `tick` is asserted for one clk when the prescaler equals PRESC-1.
  - All PWM state below advances only on tick edges.
- **Time base**
  - `cnt` counts 0..PERIOD-1 and wraps to 0.
  - The tick on which `cnt` wraps to 0 is the period start.
- **Shadow duty**
  - Each channel's `duty` is sampled into `duty_sh[i]` only at period start, and at reset release.
  - Changes to `duty` mid-period have no effect until the next period.
- **Demand**
  - `raw[i] = (cnt < duty_sh[i])`.
  - duty_sh=0 gives 0 % duty. duty_sh ≥ PERIOD gives 100 % duty.
- **Dead time, per channel**
  - `dtc[i]`, width clog2(DT+1), resets to 0 on every tick where `raw[i]` differs from its previous-tick value. Otherwise it increments, saturating at DT.
  - `s[i] = raw[i] && dtc[i]==DT`.
  - `nots[i] = !raw[i] && dtc[i]==DT`.
  - Both outputs deassert immediately on a demand change and reassert only after DT stable ticks.
  - Demand pulses shorter than DT ticks are swallowed.
  - `s[i]` and `nots[i]` are never high together.
- **Interrupt**
  - `icnt` counts period starts from 0..INT_DIV-1.
  - `irq` pulses for one clk on the clk after the period start where `icnt` wraps to 0.
- **Enable**
  - `en`=0 synchronously clears the prescaler, `cnt`, `icnt`, every `dtc` and all outputs, and keeps reloading `duty_sh` from `duty`.
  - On `en` 0→1, the first tick occurs PRESC clks later and is a period start.
- **Reset**
  - Reset clears all counters and outputs to 0.
  - Reset values: `s`=0, `nots`=0, `irq`=0.
  - Reset asserted mid-period forces all outputs low asynchronously. After release, the block behaves as if `en` had just risen.

## Timing
- Outputs lag `cnt` by one tick: `s`/`nots` update on the clk edge of the tick following the `cnt` change.
- `irq` is high for exactly 1 clk, regardless of PRESC.
- Demand-change to output-deassert latency is 1 clk after the tick.
- Demand-change to opposite-output-assert latency is DT ticks.
- `en` 1→0 to all outputs low: 1 clk.
- Per edge-aligned period with 0 < duty_sh < PERIOD:
  - `s` is high for duty_sh−DT ticks.
  - `nots` is high for PERIOD−duty_sh−DT ticks.
  - Each value is clamped at 0.

## Configuration
- Macro: `PWM_CENTER_ALIGNED_EN`.
- **Defined**
  - `cnt` counts up 0..PERIOD-1, then down to 0. The period is 2*(PERIOD-1) ticks.
  - Period start is the tick where `cnt` reaches 0 while counting down (the valley). Shadow load and interrupt counting happen there.
  - `raw[i] = (cnt < duty_sh[i])`, so the high-side pulse is centred on the valley.
- **Undefined**
  - Edge-aligned sawtooth as described above.
  - No direction register is synthesised.

## Test plan
- **Reset mid-run:** assert `rst_n`=0 while `s`=1. Required: `s`, `nots` and `irq` are 0 without waiting for a clk edge. After release, the first `irq` comes PRESC clks plus 1 clk later.
- **Nominal duty (defaults, duty=250):** per 4000-clk period, `s` high for 242 ticks (968 clks), `nots` high for 742 ticks, 8-tick gaps at both edges, and never both high.
- **Saturation:** duty=0 gives `nots` continuously high after the first 8 ticks and `s` always 0. duty=1023 gives `s` continuously high and `nots` always 0.
- **Shadow and swallowing:**
  - Changing duty 250→600 at cnt=100 gives the current period 242 ticks and the next period 592 ticks of `s`.
  - duty=5 gives no `s` pulse and `nots` high for 987 ticks per period.
- **Interrupt divider (INT_DIV=3, PRESC=1):** `irq` is a 1-clk pulse every 3000 clks, aligned to period start.
- **Enable and config:**
  - `en` 1→0 gives all outputs low the next clk.
  - With `PWM_CENTER_ALIGNED_EN`, PERIOD=1000 and duty=250, `s` is high for 2*250−1−8 = 491 ticks, centred on the valley, within a 1998-tick period.
